led_seq_ctrl: RTL
=================

// Module: led_seq_ctrl
// PURPOSE
//   Controller/sequencer for the 8-LED display path: prescales CLK into step ticks, drives a pattern
//   register through four display modes, and accepts mode commands over a valid/ready handshake.
//   Optional auto-advance cycles the modes. Sits between board control logic (buttons/UART decoder)
//   and the LEDS pins.
// PARAMETERS
//   CLK_DIV         22  prescaler width; one TICK every 2**CLK_DIV clocks while running
//   STEPS_PER_MODE  16  ticks spent in each mode when auto-advance is on (>=1)
//   PWM_BITS         4  brightness resolution; used only with LED_SEQ_PWM_EN
// PORTS
//   CLK        in   1         system clock, all state on rising edge
//   RST_N      in   1         asynchronous, active-low reset
//   CMD_VALID  in   1         command request
//   CMD_READY  out  1         command accept; transfer = CMD_VALID & CMD_READY at a rising edge
//   CMD_MODE   in   2         requested mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   CMD_AUTO   in   1         auto-advance enable, latched with the command
//   PAUSE      in   1         level; freezes sequencing
//   BRIGHT     in   PWM_BITS  duty value (port exists only with LED_SEQ_PWM_EN)
//   LEDS       out  8         LED drive
//   MODE       out  2         current mode register
//   TICK       out  1         step strobe, combinational: (presc == all ones) & (state == RUN)
// BEHAVIOUR
//   Reset (async): state RUN, MODE=0, auto=0, presc=0, step=0, pattern=8'h01, dir=left;
//     outputs LEDS=8'h01, MODE=0, TICK=0, CMD_READY=1.
//   FSM states RUN, PAUSED, LOAD. CMD_READY = 1 in RUN/PAUSED, 0 in LOAD.
//   RUN: presc increments each clock (wraps). On TICK, pattern advances at the closing edge:
//     ROT_L {p[6:0],p[7]}; ROT_R {p[0],p[7:1]}; BLINK ~p;
//     BOUNCE: shift toward dir; at 8'h80 going left -> dir=right, p=8'h40; at 8'h01 going right
//       -> dir=left, p=8'h02.
//     PAUSE=1 -> PAUSED next edge (no advance on that edge even if TICK).
//   PAUSED: presc, step, pattern hold; TICK=0; PAUSE=0 -> RUN (presc resumes from held value).
//   Command accept (RUN or PAUSED) at edge k: MODE<=CMD_MODE, auto<=CMD_AUTO, state<=LOAD.
//     Accept takes priority over a same-cycle TICK (pattern not advanced) and over auto-advance.
//   LOAD (exactly one cycle): pattern<=seed(MODE), dir<=left, presc<=0, step<=0;
//     next state = PAUSE ? PAUSED : RUN.
//     Seeds: ROT_L 8'h01, ROT_R 8'h80, BOUNCE 8'h01, BLINK 8'hFF.
//   Latency: MODE valid after edge k; seed on LEDS after edge k+1; first TICK in cycle
//     k+1+2**CLK_DIV.
//   Auto-advance (auto=1): step counts TICKs in RUN; on TICK with step==STEPS_PER_MODE-1:
//     MODE<=MODE+1 (3 wraps to 0), state<=LOAD (no pattern advance that edge).
//   CMD_MODE/CMD_AUTO sampled only at transfer; CMD_VALID held during LOAD waits (no loss).
//   Reset mid-operation (any state, incl. LOAD): returns immediately to reset values.
// CONFIGURATION
//   LED_SEQ_PWM_EN defined: BRIGHT port present; free-running PWM_BITS counter pwm (reset 0,
//     runs in all states); LEDS = pattern & {8{pwm < BRIGHT}}. BRIGHT=0 -> LEDS=0;
//     BRIGHT=all ones -> on (2**PWM_BITS-1) of every 2**PWM_BITS clocks.
//   Not defined: no BRIGHT port, no PWM counter, LEDS = pattern.
// TESTING (CLK_DIV=2, STEPS_PER_MODE=4, macro off unless stated)
//   Release RST_N -> LEDS=8'h01, MODE=0, CMD_READY=1; TICK every 4 clks; after 1/7/8 ticks
//     LEDS=8'h02/8'h80/8'h01.
//   Cmd MODE=2 -> CMD_READY=0 one cycle, LEDS=8'h01; 7 ticks -> 8'h80; 8th -> 8'h40;
//     14th -> 8'h01; 15th -> 8'h02.
//   Cmd MODE=3 -> LEDS=8'hFF, next tick 8'h00, next 8'hFF; cmd issued in a TICK cycle ->
//     no advance, seed loaded.
//   PAUSE=1 for 20 clks in ROT_L at 8'h04 -> LEDS hold 8'h04, TICK=0; release -> next tick
//     from held presc gives 8'h08.
//   Cmd MODE=1 AUTO=1 -> after 4 ticks MODE=2, CMD_READY low 1 cycle, LEDS=8'h01; MODE=3 then
//     wraps to 0 after 4 ticks each.
//   Macro on, PWM_BITS=2: BRIGHT=0 -> LEDS=0 always; BRIGHT=2 -> pattern shown 2 of every 4 clks;
//     RST_N pulse mid-LOAD -> reset values.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencer for the 8-LED display path.
// A prescaler turns clk into step ticks. Each tick advances a pattern register
// in one of four display modes: rotate left, rotate right, bounce, or blink.
// Mode commands arrive over a valid/ready handshake. Each command carries an
// auto-advance flag that makes the block step through the modes on its own.
// Optional feature macro: LED_SEQ_PWM_EN. When it is defined, the block gets a
// bright input and a free-running PWM counter that gates the LED drive.
module led_seq_ctrl #(
  parameter int CLK_DIV        = 22,
  parameter int STEPS_PER_MODE = 16,
  parameter int PWM_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic                cmd_auto,
  input  logic                pause,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_BITS-1:0] bright,
`endif
  output logic [7:0]          leds,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int STEP_W = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEPS_PER_MODE - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [CLK_DIV-1:0] PRESC_ONE = CLK_DIV'(1);
  localparam logic [CLK_DIV-1:0] PRESC_TOP = {CLK_DIV{1'b1}};

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // Direction flag used by bounce mode: 0 = moving left, 1 = moving right.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CLK_DIV-1:0] presc_r;
  logic [STEP_W-1:0]  step_r;
  logic [7:0]         pattern_r;
  logic               dir_r;
  logic [1:0]         mode_r;
  logic               auto_r;

  logic               tick_s;
  logic               accept_s;
  logic               auto_adv_s;
  logic [8:0]         next_s;

  // Pattern loaded on entry to a mode.
  function automatic logic [7:0] seed_of(input logic [1:0] m);
    logic [7:0] s;
    case (m)
      MODE_ROT_L:  s = 8'h01;
      MODE_ROT_R:  s = 8'h80;
      MODE_BOUNCE: s = 8'h01;
      MODE_BLINK:  s = 8'hFF;
      default:     s = 8'h01;
    endcase
    return s;
  endfunction

  // One step of the display pattern. The result is {dir, pattern}.
  function automatic logic [8:0] step_pattern(input logic [1:0] m,
                                              input logic [7:0] p,
                                              input logic       d);
    logic [8:0] r;
    case (m)
      MODE_ROT_L:  r = {d, p[6:0], p[7]};
      MODE_ROT_R:  r = {d, p[0], p[7:1]};
      MODE_BLINK:  r = {d, ~p};
      MODE_BOUNCE: begin
        if (d == DIR_LEFT) begin
          if (p == 8'h80) begin
            r = {DIR_RIGHT, 8'h40};
          end else begin
            r = {DIR_LEFT, p[6:0], 1'b0};
          end
        end else begin
          if (p == 8'h01) begin
            r = {DIR_LEFT, 8'h02};
          end else begin
            r = {DIR_RIGHT, 1'b0, p[7:1]};
          end
        end
      end
      default:     r = {d, p};
    endcase
    return r;
  endfunction

  // Decode the tick, command-transfer and auto-advance conditions.
  always_comb begin
    tick_s     = (presc_r == PRESC_TOP) && (state_r == ST_RUN);
    accept_s   = cmd_valid && (state_r != ST_LOAD);
    auto_adv_s = tick_s && auto_r && (step_r == STEP_LAST);
    next_s     = step_pattern(mode_r, pattern_r, dir_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. A command wins over pause and over auto-advance.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          state_nxt_s = ST_LOAD;
        end else if (pause) begin
          state_nxt_s = ST_PAUSED;
        end else if (auto_adv_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (accept_s) begin
          state_nxt_s = ST_LOAD;
        end else if (!pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_LOAD: begin
        if (pause) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Sequencing datapath: prescaler, step counter, pattern, mode and auto flag.
  // The prescaler holds on the edge that enters PAUSED. A tick that is lost
  // on that edge therefore fires again as soon as the block resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      step_r    <= '0;
      pattern_r <= 8'h01;
      dir_r     <= DIR_LEFT;
      mode_r    <= MODE_ROT_L;
      auto_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            mode_r <= cmd_mode;
            auto_r <= cmd_auto;
          end else if (pause) begin
            presc_r <= presc_r;
          end else begin
            presc_r <= presc_r + PRESC_ONE;
            if (auto_adv_s) begin
              mode_r <= mode_r + 2'd1;
            end else if (tick_s) begin
              dir_r     <= next_s[8];
              pattern_r <= next_s[7:0];
              if (auto_r) begin
                step_r <= step_r + STEP_ONE;
              end else begin
                step_r <= step_r;
              end
            end else begin
              pattern_r <= pattern_r;
            end
          end
        end
        ST_PAUSED: begin
          if (accept_s) begin
            mode_r <= cmd_mode;
            auto_r <= cmd_auto;
          end else begin
            mode_r <= mode_r;
          end
        end
        ST_LOAD: begin
          pattern_r <= seed_of(mode_r);
          dir_r     <= DIR_LEFT;
          presc_r   <= '0;
          step_r    <= '0;
        end
        default: begin
          pattern_r <= 8'h01;
          dir_r     <= DIR_LEFT;
          presc_r   <= '0;
          step_r    <= '0;
        end
      endcase
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_r;
  logic                pwm_on_s;

  // Free-running brightness counter. It runs in every FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= '0;
    end else begin
      pwm_r <= pwm_r + PWM_BITS'(1);
    end
  end

  // The LEDs are lit while the counter is below the requested duty value.
  always_comb begin
    pwm_on_s = (pwm_r < bright);
  end
`endif

  // Output decode from the state and pattern registers.
  always_comb begin
    cmd_ready = (state_r != ST_LOAD);
    tick      = tick_s;
    mode      = mode_r;
`ifdef LED_SEQ_PWM_EN
    leds      = pattern_r & {8{pwm_on_s}};
`else
    leds      = pattern_r;
`endif
  end

endmodule
